lsu_mem_port: RTL and testbench
===============================

Name: lsu_mem_port

Overview:
- Load/store unit on the data side of the execution stage.
- Takes the ALU result (effective address), the rs2 store data and funct3.
- Runs a request/response transaction on a 32-bit word data bus with byte strobes.
- Returns an aligned, sign/zero-extended load result to writeback.
- Holds `stall` high while a transaction is outstanding so the core freezes the PC.

Parameters:
- `ADDR_W`, 32: effective-address width.
- `TIMEOUT`, 255: max cycles in `WAIT` before abort; 0 disables the watchdog.

Ports:
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `mem_read` in 1: load request from decode; sampled only in `IDLE`.
- `mem_write` in 1: store request from decode; sampled only in `IDLE`.
- `fn3` in 3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `addr` in `ADDR_W`: effective address (`alu_out`).
- `wdata` in 32: store data (`rs2_data`).
- `stall` out 1: high while the unit is busy.
- `rdata_out` out 32: extended load result.
- `done` out 1: one-cycle pulse when the access completes.
- `err` out 1: one-cycle pulse on timeout or misalignment.
- `bus_req` out 1: request valid.
- `bus_we` out 1: write enable.
- `bus_addr` out `ADDR_W`: word-aligned address, bits [1:0] always 0.
- `bus_be` out 4: byte enables.
- `bus_wdata` out 32: lane-replicated store data.
- `bus_gnt` in 1: request accepted.
- `bus_rvalid` in 1: response valid.
- `bus_rdata` in 32: response data.

Behaviour:
- **Reset.** Reset is asynchronous active-low. All outputs are 0; state is `IDLE`; timeout counter is 0. Reset mid-transaction abandons it, and any `bus_rvalid` arriving after reset is ignored.
- **States.** `IDLE`, `REQ`, `WAIT`, `RESP`.
- **IDLE.**
  - `mem_read` or `mem_write` → latch `addr[1:0]`, `fn3` and direction → `REQ`, with `stall` high combinationally in that same cycle.
  - If both are high, the write wins.
- **REQ.**
  - Drives `bus_req` = 1, with `bus_addr`, `bus_be`, `bus_wdata` and `bus_we` held stable until `bus_gnt`.
  - `bus_gnt` → `WAIT`. If `bus_rvalid` arrives in the same cycle as `bus_gnt`, go straight to `RESP` and capture `bus_rdata`.
- **WAIT.**
  - `bus_req` = 0; the counter increments each cycle.
  - `bus_rvalid` → capture `bus_rdata` → `RESP`.
  - Counter reaching `TIMEOUT` (when `TIMEOUT` ≠ 0) → `err` pulse, `rdata_out` = 0 → `IDLE`.
- **RESP.**
  - `done` = 1 and `stall` = 0 for this single cycle; `rdata_out` is updated → `IDLE`.
  - Stores wait for `bus_rvalid` as the write acknowledgement.
- **Byte enables.**
  - B/BU: `4'b0001 << addr[1:0]`.
  - H/HU: `4'b0011 << addr[1:0]`.
  - W: `4'b1111`.
- **Store lanes.**
  - B: `wdata[7:0]` replicated ×4.
  - H: `wdata[15:0]` replicated ×2.
  - W: as is.
- **Load extract.**
  - Shift `bus_rdata` right by `8*addr[1:0]`.
  - B/H: sign-extend from bit 7/15.
  - BU/HU: zero-extend.
- **Timing.**
  - `rdata_out` is held between accesses.
  - Minimum latency is 3 cycles (`IDLE`→`REQ`→`RESP`) with `gnt` and `rvalid` both asserted in the `REQ` cycle.
  - `stall` drops in the `done` cycle, so the core advances on the next edge.
- **Unsupported funct3** (011, 110, 111): treated as W.

Optional Feature:
- Macro: `LSU_MISALIGN_TRAP_EN`.
- **Defined:**
  - Misaligned accesses are H/HU with `addr[0]` = 1, or W with `addr[1:0]` ≠ 0.
  - These issue no bus request: `IDLE` → one cycle in `RESP` with `err` = 1 and `done` = 1.
  - `rdata_out` is unchanged; no store occurs.
- **Not defined:** misaligned H/W accesses use `addr[1:0]` masked to 0 for lane selection and byte enables, and proceed normally without error.

Test Plan:
1. **Word load.** `mem_read`, `fn3`=010, `addr`=0x100, `gnt`+`rvalid` in the `REQ` cycle, `bus_rdata`=0xDEADBEEF → `bus_addr`=0x100, `bus_be`=1111, `done` at cycle 3, `rdata_out`=0xDEADBEEF.
2. **Signed/unsigned byte load.** `fn3`=000, `addr`=0x103, `bus_rdata`=0x80FF_0000 → `bus_be`=1000, `rdata_out`=0xFFFFFF80. Repeat with `fn3`=100 → `rdata_out`=0x00000080.
3. **Half store with delayed grant.** `mem_write`, `fn3`=001, `addr`=0x22, `wdata`=0x1234ABCD, `gnt` delayed 4 cycles, then `rvalid` 2 cycles later.
   - `bus_we`=1, `bus_be`=1100, `bus_wdata`=0xABCDABCD, all stable while `bus_req` is high.
   - `stall` high throughout until `done`.
4. **Timeout.** `TIMEOUT`=8, `gnt` given, `rvalid` never → `err` pulses 8 cycles after entering `WAIT`, `rdata_out`=0, return to `IDLE`, `stall` low.
5. **Reset mid-operation.** `rst_n` low during `WAIT` → all outputs 0 immediately. A stale `rvalid` after release produces no `done`.
6. **Misaligned word load.**
   - `LSU_MISALIGN_TRAP_EN` defined: `fn3`=010, `addr`=0x102 → no `bus_req`; `err` and `done` together on cycle 2.
   - Macro undefined: `bus_addr`=0x100, `be`=1111, normal completion.

Source files
------------

// File: rtl/lsu_mem_port.sv
//------------------------------------------------------------------------------
// Module   : lsu_mem_port
// Purpose  : Load/store unit driving a 32-bit req/gnt/rvalid word bus with byte
//            strobes; optional macro LSU_MISALIGN_TRAP_EN traps misaligned H/W.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module lsu_mem_port #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [2:0]        fn3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              stall,
  output logic [31:0]       rdata_out,
  output logic              done,
  output logic              err,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [31:0]       bus_wdata,
  input  logic              bus_gnt,
  input  logic              bus_rvalid,
  input  logic [31:0]       bus_rdata
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  localparam int              CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);

  logic [1:0]        state, next_state;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        off_q;
  logic [2:0]        fn3_q;
  logic              we_q;
  logic              trap_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic [CNT_W-1:0]  cnt;

  // Request-side decode; unsupported funct3 codes fall into the word case.
  logic        req_in, in_b, in_h, trap_in;
  logic [1:0]  off_in;
  logic [31:0] lanes_in;

  assign req_in   = mem_read | mem_write;
  assign in_b     = (fn3[1:0] == 2'b00);
  assign in_h     = (fn3[1:0] == 2'b01);
  assign off_in   = in_b ? addr[1:0] : (in_h ? {addr[1], 1'b0} : 2'b00);
  assign lanes_in = in_b ? {4{wdata[7:0]}} : (in_h ? {2{wdata[15:0]}} : wdata);

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap_in = (in_h & addr[0]) | (~in_b & ~in_h & (addr[1:0] != 2'b00));
`else
  assign trap_in = 1'b0;
`endif

  // Access-side decode from latched request.
  logic        q_b, q_h, timeout, capture;
  logic [31:0] shifted, load_val;

  assign q_b     = (fn3_q[1:0] == 2'b00);
  assign q_h     = (fn3_q[1:0] == 2'b01);
  assign shifted = bus_rdata >> {off_q, 3'b000};
  assign timeout = (TIMEOUT != 0) && (cnt == TO_VAL);
  assign capture = bus_rvalid & (((state == REQ) & bus_gnt) | (state == WAIT));

  always_comb begin
    if (q_b)
      load_val = {{24{shifted[7] & ~fn3_q[2]}}, shifted[7:0]};
    else if (q_h)
      load_val = {{16{shifted[15] & ~fn3_q[2]}}, shifted[15:0]};
    else
      load_val = shifted;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (req_in) next_state = trap_in ? RESP : REQ;
      REQ:  if (bus_gnt) next_state = bus_rvalid ? RESP : WAIT;
      WAIT: begin
        if (bus_rvalid)
          next_state = RESP;
        else if (timeout)
          next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    stall     = ((state == IDLE) & req_in) | (state == REQ) | (state == WAIT);
    done      = (state == RESP);
    err       = ((state == RESP) & trap_q) | ((state == WAIT) & ~bus_rvalid & timeout);
    bus_req   = (state == REQ);
    bus_we    = (state == REQ) & we_q;
    bus_addr  = (state == REQ) ? addr_q : '0;
    bus_wdata = (state == REQ) ? wdata_q : '0;
    bus_be    = 4'b0000;
    if (state == REQ) begin
      if (q_b)
        bus_be = 4'b0001 << off_q;
      else if (q_h)
        bus_be = 4'b0011 << off_q;
      else
        bus_be = 4'b1111;
    end
  end

  assign rdata_out = rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      off_q   <= 2'b00;
      fn3_q   <= 3'b000;
      we_q    <= 1'b0;
      trap_q  <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt     <= '0;
    end else begin
      if ((state == IDLE) && req_in) begin
        addr_q  <= {addr[ADDR_W-1:2], 2'b00};
        off_q   <= off_in;
        fn3_q   <= fn3;
        we_q    <= mem_write;
        trap_q  <= trap_in;
        wdata_q <= lanes_in;
      end
      cnt <= (state == WAIT) ? cnt + 1'b1 : '0;
      // Store acknowledgements carry no data, so rdata_out keeps the last load.
      if (capture && !we_q)
        rdata_q <= load_val;
      else if ((state == WAIT) && !bus_rvalid && timeout)
        rdata_q <= '0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_lsu_mem_port.sv
//------------------------------------------------------------------------------
// Module   : tb_lsu_mem_port
// Purpose  : Directed scoreboard bench for lsu_mem_port (TIMEOUT = 8).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_lsu_mem_port;

  logic        clk = 1'b0;
  logic        rst_n, mem_read, mem_write, bus_gnt, bus_rvalid;
  logic [2:0]  fn3;
  logic [31:0] addr, wdata, bus_rdata;
  logic        stall, done, err, bus_req, bus_we;
  logic [31:0] rdata_out, bus_addr, bus_wdata;
  logic [3:0]  bus_be;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        done;
    logic        chk_rd;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   lat;

  lsu_mem_port #(.ADDR_W(32), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
    .fn3(fn3), .addr(addr), .wdata(wdata), .stall(stall), .rdata_out(rdata_out),
    .done(done), .err(err), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] rd, input logic e, input logic d, input logic c);
    exp_t x;
    x.rdata = rd; x.err = e; x.done = d; x.chk_rd = c;
    sb.push_back(x);
  endtask

  // Called just after a rising edge in IDLE; returns just after the edge into REQ/RESP.
  task automatic issue(input logic rd, input logic wr, input logic [2:0] f,
                       input logic [31:0] a, input logic [31:0] wd);
    mem_read = rd; mem_write = wr; fn3 = f; addr = a; wdata = wd;
    @(negedge clk);
    chk("stall_on_issue", stall, 1);
    tick();
    mem_read = 0; mem_write = 0; addr = '1; wdata = '0;
  endtask

  // Waits for done/err, pops the scoreboard and compares; ends at a falling edge.
  task automatic expect_resp(input int budget, output int n);
    exp_t e;
    n = 0;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (done || err) begin
        n = i;
        break;
      end
    end
    if (n == 0) begin
      chk("resp_seen", {31'b0, done | err}, 1);
    end else if (sb.size() == 0) begin
      chk("unexpected_resp", {31'b0, done | err}, 0);
    end else begin
      e = sb.pop_front();
      chk("resp_err", err, e.err);
      chk("resp_done", done, e.done);
      if (e.chk_rd) chk("resp_rdata", rdata_out, e.rdata);
      if (e.done) chk("stall_low_in_done", stall, 0);
    end
  endtask

  initial begin
    rst_n = 0; mem_read = 0; mem_write = 0; fn3 = 0; addr = 0; wdata = 0;
    bus_gnt = 0; bus_rvalid = 0; bus_rdata = 0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", stall, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_bus_req", bus_req, 0);
    chk("rst_bus_be", bus_be, 0);
    chk("rst_rdata", rdata_out, 0);
    tick();
    rst_n = 1;
    tick();

    // Word load, minimum latency
    push(32'hDEADBEEF, 0, 1, 1);
    issue(1, 0, 3'b010, 32'h100, 0);
    bus_gnt = 1; bus_rvalid = 1; bus_rdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("w_bus_req", bus_req, 1);
    chk("w_bus_addr", bus_addr, 32'h100);
    chk("w_bus_be", bus_be, 4'b1111);
    chk("w_bus_we", bus_we, 0);
    tick();
    bus_gnt = 0; bus_rvalid = 0;
    expect_resp(1, lat);
    chk("w_latency", lat, 1);
    tick();

    // Signed byte load
    push(32'hFFFFFF80, 0, 1, 1);
    issue(1, 0, 3'b000, 32'h103, 0);
    bus_gnt = 1; bus_rvalid = 1; bus_rdata = 32'h80FF_0000;
    @(negedge clk);
    chk("b_bus_be", bus_be, 4'b1000);
    tick();
    bus_gnt = 0; bus_rvalid = 0;
    expect_resp(1, lat);
    tick();

    // Unsigned byte load
    push(32'h00000080, 0, 1, 1);
    issue(1, 0, 3'b100, 32'h103, 0);
    bus_gnt = 1; bus_rvalid = 1; bus_rdata = 32'h80FF_0000;
    tick();
    bus_gnt = 0; bus_rvalid = 0;
    expect_resp(1, lat);
    tick();

    // Half store, grant delayed 4 cycles, ack 2 cycles after grant
    push(32'h00000080, 0, 1, 1);
    issue(0, 1, 3'b001, 32'h22, 32'h1234ABCD);
    for (int i = 0; i < 5; i++) begin
      if (i == 4) bus_gnt = 1;
      @(negedge clk);
      chk("hs_bus_req", bus_req, 1);
      chk("hs_bus_we", bus_we, 1);
      chk("hs_bus_be", bus_be, 4'b1100);
      chk("hs_bus_wdata", bus_wdata, 32'hABCDABCD);
      chk("hs_bus_addr", bus_addr, 32'h20);
      chk("hs_stall", stall, 1);
      tick();
    end
    bus_gnt = 0;
    @(negedge clk);
    chk("hs_wait_req", bus_req, 0);
    chk("hs_wait_stall", stall, 1);
    tick();
    bus_rvalid = 1;
    @(negedge clk);
    chk("hs_ack_stall", stall, 1);
    tick();
    bus_rvalid = 0;
    expect_resp(1, lat);
    tick();

    // Timeout after 8 WAIT cycles
    push(32'h0, 1, 0, 0);
    issue(1, 0, 3'b010, 32'h40, 0);
    bus_gnt = 1;
    tick();
    bus_gnt = 0;
    expect_resp(12, lat);
    chk("to_latency", lat, 9);
    chk("to_stall_at_err", stall, 1);
    tick();
    @(negedge clk);
    chk("to_rdata_zero", rdata_out, 0);
    chk("to_stall_idle", stall, 0);
    chk("to_err_pulse", err, 0);
    tick();

    // Word load to leave a non-zero result
    push(32'h5A5A1234, 0, 1, 1);
    issue(1, 0, 3'b010, 32'h104, 0);
    bus_gnt = 1; bus_rvalid = 1; bus_rdata = 32'h5A5A1234;
    tick();
    bus_gnt = 0; bus_rvalid = 0;
    expect_resp(1, lat);
    tick();

    // Misaligned word load
`ifdef LSU_MISALIGN_TRAP_EN
    push(32'h5A5A1234, 1, 1, 1);
    issue(1, 0, 3'b010, 32'h102, 0);
    expect_resp(1, lat);
    chk("mis_no_bus_req", bus_req, 0);
`else
    push(32'hCAFEF00D, 0, 1, 1);
    issue(1, 0, 3'b010, 32'h102, 0);
    bus_gnt = 1; bus_rvalid = 1; bus_rdata = 32'hCAFEF00D;
    @(negedge clk);
    chk("mis_bus_addr", bus_addr, 32'h100);
    chk("mis_bus_be", bus_be, 4'b1111);
    tick();
    bus_gnt = 0; bus_rvalid = 0;
    expect_resp(1, lat);
`endif
    tick();

    // Reset during WAIT, then a stale response
    issue(1, 0, 3'b010, 32'h80, 0);
    bus_gnt = 1;
    tick();
    bus_gnt = 0;
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("mrst_stall", stall, 0);
    chk("mrst_bus_req", bus_req, 0);
    chk("mrst_done", done, 0);
    chk("mrst_err", err, 0);
    chk("mrst_rdata", rdata_out, 0);
    tick();
    rst_n = 1; bus_rvalid = 1; bus_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    chk("stale_done", done, 0);
    chk("stale_stall", stall, 0);
    tick();
    bus_rvalid = 0;
    @(negedge clk);
    chk("stale_done_late", done, 0);
    chk("stale_rdata", rdata_out, 0);

    chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
